clk_ratio_meter: RTL and testbench

Measures a divided clock (typically the output of the configurable clock divider) against the reference clock i_ref_clk. It recovers the division ratio and the high/low phase widths. It compares them against the programmed expected ratio and flags lock, mismatch and stall conditions. It is the checking end of the divider: it runs in the i_ref_clk domain and feeds status to the register file and system controller.

---
 rtl/clk_meter_pkg.sv | 28 ++
 rtl/clk_edge_sampler.sv | 44 ++++
 rtl/clk_ratio_meter.sv | 148 ++++++++++++++
 tb/tb_clk_ratio_meter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// Shared types, default sizing and the duty-cycle rule for the divided-clock ratio meter.
// Pure definitions: no latency, no flow control.
package clk_meter_pkg;

   localparam int DEF_RATIO_SIZE = 4;
   localparam int DEF_CNT_WIDTH  = 6;
   localparam int DEF_TIMEOUT    = 32;
   localparam int DEF_LOCK_CNT   = 2;
   localparam int METER_ARG_W    = 16;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      MEAS_HIGH,
      MEAS_LOW,
      STALL
   } meter_state_e;

   // An even ratio must split evenly; an odd ratio may only be off by one cycle either way.
   function automatic logic duty_ok(input logic [METER_ARG_W-1:0] high,
                                    input logic [METER_ARG_W-1:0] low,
                                    input logic                   odd);
      logic [METER_ARG_W-1:0] diff;
      diff = (high > low) ? (high - low) : (low - high);
      return odd ? (diff == METER_ARG_W'(1)) : (diff == '0);
   endfunction

endpackage

// File: rtl/clk_edge_sampler.sv
// Samples i_div_clk as data and flags rise/fall; 1 cycle to s, +2 with CLK_METER_SYNC_EN.
// No backpressure: edge flags are combinational from the sample registers, valid every cycle.
module clk_edge_sampler (
   input  logic i_ref_clk,
   input  logic i_rst_n,
   input  logic i_div_clk,
   output logic o_rise,
   output logic o_fall
);

   logic div_in;
   logic s_q;
   logic s_d;

`ifdef CLK_METER_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], i_div_clk};
      end
   end

   assign div_in = sync_q[1];
`else
   assign div_in = i_div_clk;
`endif

   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s_q <= 1'b0;
         s_d <= 1'b0;
      end else begin
         s_q <= div_in;
         s_d <= s_q;
      end
   end

   assign o_rise = s_q & ~s_d;
   assign o_fall = ~s_q & s_d;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures divided-clock period and phase widths against i_ref_clk, checks them and tracks lock/stall.
// o_valid 2 cycles after the sampled rise (+2 with CLK_METER_SYNC_EN); no backpressure, status only.
module clk_ratio_meter
   import clk_meter_pkg::*;
#(
   parameter int RATIO_SIZE = DEF_RATIO_SIZE,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
   parameter int TIMEOUT    = DEF_TIMEOUT,
   parameter int LOCK_CNT   = DEF_LOCK_CNT
) (
   input  logic                  i_ref_clk,
   input  logic                  i_rst_n,
   input  logic                  i_enable,
   input  logic                  i_div_clk,
   input  logic [RATIO_SIZE-1:0] i_expected_ratio,
   output logic [RATIO_SIZE-1:0] o_ratio,
   output logic [CNT_WIDTH-1:0]  o_high_cnt,
   output logic [CNT_WIDTH-1:0]  o_low_cnt,
   output logic                  o_valid,
   output logic                  o_locked,
   output logic                  o_mismatch,
   output logic                  o_stall
);

   localparam int                   SUM_W     = CNT_WIDTH + 1;
   localparam logic [SUM_W-1:0]     RMAX_SUM  = SUM_W'((1 << RATIO_SIZE) - 1);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);
   localparam logic [2:0]           LOCK_C    = 3'(LOCK_CNT);

   meter_state_e          state;
   logic [CNT_WIDTH-1:0]  phase_cnt;
   logic [CNT_WIDTH-1:0]  high_q;
   logic [2:0]            good_cnt;
   logic [RATIO_SIZE-1:0] exp_q;

   logic             rise;
   logic             fall;
   logic             edge_seen;
   logic             run;
   logic             timeout;
   logic [SUM_W-1:0] sum;
   logic             good;

   clk_edge_sampler u_sampler (
      .i_ref_clk (i_ref_clk),
      .i_rst_n   (i_rst_n),
      .i_div_clk (i_div_clk),
      .o_rise    (rise),
      .o_fall    (fall)
   );

   // Ratios 0 and 1 mean the divider is bypassed: nothing sampleable.
   assign run       = i_enable && (i_expected_ratio >= RATIO_SIZE'(2));
   assign edge_seen = rise | fall;
   assign timeout   = (phase_cnt == TIMEOUT_C) && !edge_seen;
   assign sum       = SUM_W'(high_q) + SUM_W'(phase_cnt);
   assign good      = (sum == SUM_W'(i_expected_ratio)) &&
                      duty_ok(METER_ARG_W'(high_q), METER_ARG_W'(phase_cnt), i_expected_ratio[0]);

   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         phase_cnt <= '0;
      end else if (!run || state == IDLE) begin
         phase_cnt <= '0;
      end else if (edge_seen) begin
         phase_cnt <= ONE_C;
      end else if (phase_cnt != TIMEOUT_C) begin
         phase_cnt <= phase_cnt + ONE_C;
      end
   end

   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         high_q     <= '0;
         good_cnt   <= '0;
         exp_q      <= '0;
         o_ratio    <= '0;
         o_high_cnt <= '0;
         o_low_cnt  <= '0;
         o_valid    <= 1'b0;
         o_locked   <= 1'b0;
         o_mismatch <= 1'b0;
         o_stall    <= 1'b0;
      end else begin
         o_valid    <= 1'b0;
         o_mismatch <= 1'b0;
         exp_q      <= i_expected_ratio;
         if (!run) begin
            state    <= IDLE;
            good_cnt <= '0;
            o_locked <= 1'b0;
            o_stall  <= 1'b0;
         end else if (state != IDLE && i_expected_ratio != exp_q) begin
            state    <= ALIGN;
            good_cnt <= '0;
            o_locked <= 1'b0;
         end else begin
            if (edge_seen) begin
               o_stall <= 1'b0;
            end
            case (state)
               IDLE: state <= ALIGN;
               STALL: begin
                  if (rise) begin
                     state <= MEAS_HIGH;
                  end else if (fall) begin
                     state <= ALIGN;
                  end
               end
               default: begin
                  if (timeout) begin
                     state    <= STALL;
                     good_cnt <= '0;
                     o_locked <= 1'b0;
                     o_stall  <= 1'b1;
                  end else if (state == ALIGN && rise) begin
                     state <= MEAS_HIGH;
                  end else if (state == MEAS_HIGH && fall) begin
                     high_q <= phase_cnt;
                     state  <= MEAS_LOW;
                  end else if (state == MEAS_LOW && rise) begin
                     state      <= MEAS_HIGH;
                     o_high_cnt <= high_q;
                     o_low_cnt  <= phase_cnt;
                     o_ratio    <= (sum > RMAX_SUM) ? '1 : sum[RATIO_SIZE-1:0];
                     o_valid    <= 1'b1;
                     if (good) begin
                        if (good_cnt != LOCK_C) begin
                           good_cnt <= good_cnt + 3'd1;
                        end
                        if (good_cnt >= LOCK_C - 3'd1) begin
                           o_locked <= 1'b1;
                        end
                     end else begin
                        good_cnt   <= '0;
                        o_locked   <= 1'b0;
                        o_mismatch <= 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: table of periodic divider patterns plus multi-cycle corner sequences.
module tb_clk_ratio_meter;

   logic       i_ref_clk = 1'b0;
   logic       i_rst_n   = 1'b0;
   logic       i_enable  = 1'b0;
   logic       i_div_clk = 1'b0;
   logic [3:0] i_expected_ratio = 4'd0;
   logic [3:0] o_ratio;
   logic [5:0] o_high_cnt;
   logic [5:0] o_low_cnt;
   logic       o_valid;
   logic       o_locked;
   logic       o_mismatch;
   logic       o_stall;

   clk_ratio_meter dut (
      .i_ref_clk        (i_ref_clk),
      .i_rst_n          (i_rst_n),
      .i_enable         (i_enable),
      .i_div_clk        (i_div_clk),
      .i_expected_ratio (i_expected_ratio),
      .o_ratio          (o_ratio),
      .o_high_cnt       (o_high_cnt),
      .o_low_cnt        (o_low_cnt),
      .o_valid          (o_valid),
      .o_locked         (o_locked),
      .o_mismatch       (o_mismatch),
      .o_stall          (o_stall)
   );

   always #5 i_ref_clk = ~i_ref_clk;

   typedef struct {
      int h;
      int l;
      int e;
      int n;
      int ratio;
      int mis;
   } vec_t;

   typedef struct {
      int ratio;
      int high;
      int low;
      int mis;
      int lock;
   } exp_t;

   int     n_checks = 0;
   int     n_fail   = 0;
   int     cyc      = 0;
   int     rise_cyc = 0;
   int     tb_good  = 0;
   logic   prev_d   = 1'b0;
   exp_t   q[$];
   vec_t   vecs[8];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_ratio"}, int'(o_ratio), 0);
      chk({tag, "_high"}, int'(o_high_cnt), 0);
      chk({tag, "_low"}, int'(o_low_cnt), 0);
      chk({tag, "_valid"}, int'(o_valid), 0);
      chk({tag, "_locked"}, int'(o_locked), 0);
      chk({tag, "_mismatch"}, int'(o_mismatch), 0);
      chk({tag, "_stall"}, int'(o_stall), 0);
   endtask

   // One ref cycle: drive the divided clock level, then look at the outputs 1ns after the edge.
   task automatic step(input logic d);
      exp_t e;
      if (d && !prev_d) rise_cyc = cyc;
      prev_d    = d;
      i_div_clk = d;
      @(posedge i_ref_clk);
      cyc++;
      #1;
      if (o_mismatch && !o_valid) chk("mismatch_without_valid", 1, 0);
      if (o_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            e = q.pop_front();
            chk("ratio", int'(o_ratio), e.ratio);
            chk("high_cnt", int'(o_high_cnt), e.high);
            chk("low_cnt", int'(o_low_cnt), e.low);
            chk("mismatch", int'(o_mismatch), e.mis);
            chk("locked_at_valid", int'(o_locked), e.lock);
            chk("valid_latency", cyc - rise_cyc, 2);
         end
      end
   endtask

   task automatic drive_period(input int h, input int l, input bit push, input int ratio, input int mis);
      exp_t e;
      repeat (h) step(1'b1);
      repeat (l) step(1'b0);
      if (push) begin
         if (mis != 0) tb_good = 0;
         else if (tb_good < 2) tb_good++;
         e.ratio = ratio;
         e.high  = h;
         e.low   = l;
         e.mis   = mis;
         e.lock  = (tb_good >= 2) ? 1 : 0;
         q.push_back(e);
      end
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      @(posedge i_ref_clk);
      #3 i_rst_n = 1'b1;
      q.delete();
      tb_good = 0;
   endtask

   task automatic end_scenario(input string tag, input int lock_exp);
      chk({tag, "_pending_valids"}, q.size(), 0);
      chk({tag, "_locked_end"}, int'(o_locked), lock_exp);
      q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{h: 2,  l: 2,  e: 4,  n: 3, ratio: 4,  mis: 0};
      vecs[1] = '{h: 3,  l: 2,  e: 5,  n: 3, ratio: 5,  mis: 0};
      vecs[2] = '{h: 2,  l: 2,  e: 6,  n: 3, ratio: 4,  mis: 1};
      vecs[3] = '{h: 10, l: 10, e: 15, n: 2, ratio: 15, mis: 1};
      vecs[4] = '{h: 1,  l: 1,  e: 2,  n: 3, ratio: 2,  mis: 0};
      vecs[5] = '{h: 2,  l: 3,  e: 5,  n: 3, ratio: 5,  mis: 0};
      vecs[6] = '{h: 4,  l: 2,  e: 6,  n: 2, ratio: 6,  mis: 1};
      vecs[7] = '{h: 7,  l: 7,  e: 14, n: 2, ratio: 14, mis: 0};

      #2;
      chk_zero_outputs("reset");
      repeat (2) @(posedge i_ref_clk);

      for (int v = 0; v < 8; v++) begin
         do_reset();
         i_expected_ratio = 4'(vecs[v].e);
         i_enable = 1'b1;
         repeat (3) step(1'b0);
         for (int p = 0; p < vecs[v].n; p++)
            drive_period(vecs[v].h, vecs[v].l, 1'b1, vecs[v].ratio, vecs[v].mis);
         repeat (4) step(1'b1);
         end_scenario($sformatf("vec%0d", v), (vecs[v].mis == 0 && vecs[v].n >= 2) ? 1 : 0);
      end

      // Ratio 5: lock, one 4/2 period breaks lock, two good periods relock.
      do_reset();
      i_expected_ratio = 4'd5;
      repeat (3) step(1'b0);
      drive_period(3, 2, 1'b1, 5, 0);
      drive_period(3, 2, 1'b1, 5, 0);
      drive_period(4, 2, 1'b1, 6, 1);
      drive_period(3, 2, 1'b1, 5, 0);
      drive_period(3, 2, 1'b1, 5, 0);
      repeat (4) step(1'b1);
      end_scenario("relock5", 1);

      // Stall after lock, then resume.
      do_reset();
      i_expected_ratio = 4'd4;
      repeat (3) step(1'b0);
      repeat (3) drive_period(2, 2, 1'b1, 4, 0);
      repeat (2) step(1'b1);
      chk("pre_stall_locked", int'(o_locked), 1);
      for (int i = 1; i <= 34; i++) begin
         step(1'b0);
         if (i == 33) begin
            chk("stall_before_timeout", int'(o_stall), 0);
            chk("locked_before_timeout", int'(o_locked), 1);
         end
         if (i == 34) begin
            chk("stall_at_timeout", int'(o_stall), 1);
            chk("locked_at_timeout", int'(o_locked), 0);
         end
      end
      repeat (4) step(1'b0);
      chk("stall_held", int'(o_stall), 1);
      tb_good = 0;
      step(1'b1);
      chk("stall_until_rise_seen", int'(o_stall), 1);
      step(1'b1);
      chk("stall_cleared_on_rise", int'(o_stall), 0);
      drive_period(0, 2, 1'b1, 4, 0);
      q[q.size()-1].high = 2;
      drive_period(2, 2, 1'b1, 4, 0);
      drive_period(2, 2, 1'b1, 4, 0);
      repeat (4) step(1'b1);
      end_scenario("stall_resume", 1);
      chk("stall_end", int'(o_stall), 0);

      // Asynchronous reset in the middle of a low phase.
      do_reset();
      i_expected_ratio = 4'd4;
      repeat (3) step(1'b0);
      repeat (2) drive_period(2, 2, 1'b1, 4, 0);
      repeat (2) step(1'b1);
      repeat (2) step(1'b0);
      chk("pre_reset_pending", q.size(), 0);
      chk("pre_reset_locked", int'(o_locked), 1);
      i_rst_n = 1'b0;
      #1;
      chk_zero_outputs("midreset");
      @(posedge i_ref_clk);
      #3 i_rst_n = 1'b1;
      tb_good = 0;
      repeat (3) step(1'b0);
      repeat (2) drive_period(2, 2, 1'b1, 4, 0);
      repeat (4) step(1'b1);
      end_scenario("after_reset", 1);

      // Bypass ratio: no results, status cleared; recovers through ALIGN.
      i_expected_ratio = 4'd1;
      step(1'b1);
      chk("bypass_locked", int'(o_locked), 0);
      chk("bypass_stall", int'(o_stall), 0);
      repeat (2) step(1'b0);
      repeat (4) drive_period(2, 2, 1'b0, 0, 0);
      chk("bypass_no_result", q.size(), 0);
      i_expected_ratio = 4'd4;
      tb_good = 0;
      repeat (2) step(1'b0);
      repeat (2) drive_period(2, 2, 1'b1, 4, 0);
      repeat (4) step(1'b1);
      end_scenario("after_bypass", 1);

      // Expected ratio change while locked: lock drops, last results held.
      i_expected_ratio = 4'd6;
      step(1'b1);
      chk("ratio_change_locked", int'(o_locked), 0);
      chk("ratio_change_held", int'(o_ratio), 4);
      tb_good = 0;
      repeat (2) step(1'b0);
      repeat (2) drive_period(3, 3, 1'b1, 6, 0);
      repeat (4) step(1'b1);
      end_scenario("after_change", 1);

      // Enable drop on the same cycle the closing rise is seen: no result.
      repeat (3) step(1'b0);
      step(1'b1);
      i_enable = 1'b0;
      step(1'b1);
      chk("enable_drop_valid", int'(o_valid), 0);
      chk("enable_drop_locked", int'(o_locked), 0);
      repeat (3) step(1'b1);
      chk("enable_drop_pending", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
